// File: rtl/misao_mem_bridge.sv
// Nibble-wide core to byte-wide external memory bridge with a one-byte read buffer.
// Writes are read-modify-write: the target byte is fetched (or taken from the buffer) and one nibble replaced.
module misao_mem_bridge #(
    parameter bit BUF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] core_addr,
    input  logic        core_rw,
    input  logic [3:0]  core_wdata,
    output logic [3:0]  core_rdata,
    output logic        core_rd_en,
    output logic        core_wr_en,
    input  logic        inv,
    output logic        busy,
    output logic        ext_req,
    output logic        ext_we,
    output logic [14:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata
);

    typedef enum logic [2:0] {IDLE, FILL, RESP, WCAP, WFILL, WRITE} state_t;

    state_t      state, state_d;
    logic [15:0] lat_addr, lat_addr_d;
    logic [3:0]  wnib, wnib_d;
    logic        buf_valid, buf_valid_d;
    logic [14:0] buf_tag, buf_tag_d;
    logic [7:0]  buf_data, buf_data_d;
    logic [3:0]  core_rdata_d;
    logic        core_rd_en_d, core_wr_en_d, busy_d, ext_req_d, ext_we_d;
    logic [14:0] ext_addr_d;
    logic [7:0]  ext_wdata_d;
    logic        acc_hit, lat_hit;

    function automatic logic [3:0] pick(input logic [7:0] b, input logic sel);
        return sel ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [7:0] merge(input logic [7:0] b, input logic [3:0] n, input logic sel);
        return sel ? {n, b[3:0]} : {b[7:4], n};
    endfunction

    // Reads decide hit on the address being accepted; writes decide one cycle later on the latched one.
    assign acc_hit = BUF_EN && buf_valid && (core_addr[15:1] == buf_tag);
    assign lat_hit = BUF_EN && buf_valid && (lat_addr[15:1] == buf_tag);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d      = state;
        lat_addr_d   = lat_addr;
        wnib_d       = wnib;
        buf_valid_d  = buf_valid;
        buf_tag_d    = buf_tag;
        buf_data_d   = buf_data;
        core_rdata_d = core_rdata;
        core_rd_en_d = 1'b0;
        core_wr_en_d = 1'b0;
        ext_req_d    = ext_req;
        ext_we_d     = ext_we;
        ext_addr_d   = ext_addr;
        ext_wdata_d  = ext_wdata;

        case (state)
            IDLE: begin
                lat_addr_d = core_addr;
                if (!core_rw) begin
                    state_d      = WCAP;
                    core_wr_en_d = 1'b1;
                end else if (acc_hit) begin
                    state_d      = RESP;
                    core_rd_en_d = 1'b1;
                    core_rdata_d = pick(buf_data, core_addr[0]);
                end else begin
                    state_d    = FILL;
                    ext_req_d  = 1'b1;
                    ext_we_d   = 1'b0;
                    ext_addr_d = core_addr[15:1];
                end
            end
            FILL: begin
                if (ext_ack) begin
                    state_d      = RESP;
                    buf_data_d   = ext_rdata;
                    buf_tag_d    = lat_addr[15:1];
                    buf_valid_d  = 1'b1;
                    ext_req_d    = 1'b0;
                    core_rd_en_d = 1'b1;
                    core_rdata_d = pick(ext_rdata, lat_addr[0]);
                end
            end
            RESP: state_d = IDLE;
            WCAP: begin
                wnib_d     = core_wdata;
                ext_req_d  = 1'b1;
                ext_addr_d = lat_addr[15:1];
                if (lat_hit) begin
                    state_d     = WRITE;
                    ext_we_d    = 1'b1;
                    ext_wdata_d = merge(buf_data, core_wdata, lat_addr[0]);
                end else begin
                    state_d  = WFILL;
                    ext_we_d = 1'b0;
                end
            end
            WFILL: begin
                if (ext_ack) begin
                    state_d     = WRITE;
                    buf_data_d  = ext_rdata;
                    buf_tag_d   = lat_addr[15:1];
                    buf_valid_d = 1'b1;
                    ext_req_d   = 1'b0;
                    ext_we_d    = 1'b1;
                    ext_wdata_d = merge(ext_rdata, wnib, lat_addr[0]);
                end
            end
            WRITE: begin
                // Entered from WFILL with ext_req low for one cycle; an ack then is not ours.
                if (!ext_req) begin
                    ext_req_d = 1'b1;
                end else if (ext_ack) begin
                    state_d     = IDLE;
                    buf_data_d  = ext_wdata;
                    buf_tag_d   = lat_addr[15:1];
                    buf_valid_d = 1'b1;
                    ext_req_d   = 1'b0;
                    ext_we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inv) buf_valid_d = 1'b0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the buffer registers are reset as well, so the first access after reset always misses.
        if (rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            wnib       <= '0;
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= '0;
            core_rdata <= '0;
            core_rd_en <= 1'b0;
            core_wr_en <= 1'b0;
            busy       <= 1'b0;
            ext_req    <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
        end else begin
            state      <= state_d;
            lat_addr   <= lat_addr_d;
            wnib       <= wnib_d;
            buf_valid  <= buf_valid_d;
            buf_tag    <= buf_tag_d;
            buf_data   <= buf_data_d;
            core_rdata <= core_rdata_d;
            core_rd_en <= core_rd_en_d;
            core_wr_en <= core_wr_en_d;
            busy       <= busy_d;
            ext_req    <= ext_req_d;
            ext_we     <= ext_we_d;
            ext_addr   <= ext_addr_d;
            ext_wdata  <= ext_wdata_d;
        end
    end

endmodule

// File: tb/tb_misao_mem_bridge.sv
// Self-checking bench for misao_mem_bridge: transaction-level memory/buffer model drives per-cycle
// expectations that a negedge compare process checks; directed scenarios pin the model with literals.
module tb_misao_mem_bridge;

    localparam bit BUF_EN = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] core_addr;
    logic        core_rw;
    logic [3:0]  core_wdata;
    logic [3:0]  core_rdata;
    logic        core_rd_en, core_wr_en;
    logic        inv;
    logic        busy;
    logic        ext_req, ext_we;
    logic [14:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;

    misao_mem_bridge #(.BUF_EN(BUF_EN)) dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_rw(core_rw), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
        .inv(inv), .busy(busy),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: external memory contents and what the buffer holds (tag + valid).
    logic [7:0]  mem [0:32767];
    bit          m_valid;
    logic [14:0] m_tag;
    int          inv_rate;
    bit          force_inv;
    bit          chk_en;

    // Per-cycle expectations for the current cycle.
    logic        exp_busy, exp_rd_en, exp_wr_en, exp_req, exp_we;
    logic [3:0]  exp_rdata;
    logic [14:0] exp_addr;
    logic [7:0]  exp_wdata;

    // Observations for the directed literal checks.
    int          req_rises = 0;
    int          rd_cnt = 0;
    logic        prev_req = 1'b0;
    logic [14:0] obs_addr = '0;
    logic [3:0]  obs_rdata = '0;
    logic [7:0]  obs_wdata = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] mem_nibble(input logic [14:0] b, input bit sel);
        logic [7:0] v;
        v = mem[b] >> (4 * sel);
        return v[3:0];
    endfunction

    function automatic logic [7:0] mem_merged(input logic [14:0] b, input bit sel, input logic [3:0] wd);
        logic [7:0] mask, ins;
        mask = 8'h0F << (4 * sel);
        ins  = {4'h0, wd} << (4 * sel);
        return (mem[b] & ~mask) | ins;
    endfunction

    task automatic set_exp(input logic b, input logic rd, input logic [3:0] rdat, input logic wr,
                           input logic req, input logic we, input logic [14:0] a, input logic [7:0] wdat);
        exp_busy = b; exp_rd_en = rd; exp_rdata = rdat; exp_wr_en = wr;
        exp_req = req; exp_we = we; exp_addr = a; exp_wdata = wdat;
    endtask

    // Advance one cycle; an inv seen at the edge empties the model buffer.
    task automatic step();
        @(posedge clk);
        if (inv) m_valid = 1'b0;
        #1;
        inv       = (inv_rate != 0) && ($urandom_range(0, inv_rate - 1) == 0);
        ext_ack   = 1'b0;
        ext_rdata = 8'($urandom);
    endtask

    // External read of byte b: lat wait cycles, then one ack cycle returning memory contents.
    task automatic fetch(input logic [14:0] b, input int lat);
        repeat (lat) begin
            set_exp(1, 0, exp_rdata, 0, 1, 0, b, exp_wdata);
            step();
        end
        set_exp(1, 0, exp_rdata, 0, 1, 0, b, exp_wdata);
        ext_ack   = 1'b1;
        ext_rdata = mem[b];
        if (force_inv) inv = 1'b1;
        m_valid = 1'b1;
        m_tag   = b;
        step();
    endtask

    // One core access starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic txn(input bit rw, input logic [15:0] addr, input logic [3:0] wd, input int lat);
        logic [14:0] b;
        bit          sel, hit;
        logic [7:0]  merged;
        b   = addr[15:1];
        sel = addr[0];
        set_exp(0, 0, exp_rdata, 0, 0, 0, exp_addr, exp_wdata);
        core_addr  = addr;
        core_rw    = rw;
        core_wdata = 4'($urandom);
        ext_ack    = 1'($urandom);
        hit = BUF_EN && m_valid && (m_tag == b);
        step();
        core_addr = 16'($urandom);
        core_rw   = 1'($urandom);
        if (rw) begin
            if (!hit) fetch(b, lat);
            set_exp(1, 1, mem_nibble(b, sel), 0, 0, 0, exp_addr, exp_wdata);
            ext_ack = 1'($urandom);
            step();
        end else begin
            set_exp(1, 0, exp_rdata, 1, 0, 0, exp_addr, exp_wdata);
            core_wdata = wd;
            ext_ack    = 1'($urandom);
            hit    = BUF_EN && m_valid && (m_tag == b);
            merged = mem_merged(b, sel, wd);
            step();
            core_wdata = 4'($urandom);
            if (!hit) begin
                fetch(b, lat);
                set_exp(1, 0, exp_rdata, 0, 0, 1, b, merged);
                step();
            end
            repeat (lat) begin
                set_exp(1, 0, exp_rdata, 0, 1, 1, b, merged);
                step();
            end
            set_exp(1, 0, exp_rdata, 0, 1, 1, b, merged);
            ext_ack   = 1'b1;
            ext_rdata = 8'($urandom);
            m_valid   = 1'b1;
            m_tag     = b;
            mem[b]    = merged;
            step();
        end
        set_exp(0, 0, exp_rdata, 0, 0, 0, exp_addr, exp_wdata);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("core_rd_en", core_rd_en, exp_rd_en);
            check("core_wr_en", core_wr_en, exp_wr_en);
            check("ext_req", ext_req, exp_req);
            check("ext_we", ext_we, exp_we);
            if (exp_rd_en) check("core_rdata", core_rdata, exp_rdata);
            if (exp_req)   check("ext_addr", ext_addr, exp_addr);
            if (exp_we)    check("ext_wdata", ext_wdata, exp_wdata);
        end
    end

    always @(negedge clk) begin
        if (ext_req && !prev_req) begin
            req_rises++;
            obs_addr = ext_addr;
        end
        prev_req = ext_req;
        if (core_rd_en) begin
            rd_cnt++;
            obs_rdata = core_rdata;
        end
        if (ext_req && ext_we) obs_wdata = ext_wdata;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int r0, c0;
        rst = 1'b1; core_addr = '0; core_rw = 1'b1; core_wdata = '0;
        inv = 1'b0; ext_ack = 1'b0; ext_rdata = '0;
        inv_rate = 0; force_inv = 1'b0; chk_en = 1'b0;
        m_valid = 1'b0; m_tag = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        set_exp(0, 0, '0, 0, 0, 0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", core_rd_en, 0);
        check("rst_wr_en", core_wr_en, 0);
        check("rst_ext_req", ext_req, 0);
        check("rst_ext_we", ext_we, 0);
        check("rst_rdata", core_rdata, 0);
        check("rst_ext_addr", ext_addr, 0);
        check("rst_ext_wdata", ext_wdata, 0);

        mem[15'h0012] = 8'hA5;
        mem[15'h0800] = 8'h00;
        rst = 1'b0;
        chk_en = 1'b1;

        // Read miss, then read hit on the other nibble.
        r0 = req_rises;
        txn(1, 16'h0025, 4'h0, 3);
        check("miss_req_count", req_rises - r0, 1);
        check("miss_addr", obs_addr, 15'h0012);
        check("miss_rdata", obs_rdata, 4'hA);
        r0 = req_rises;
        txn(1, 16'h0024, 4'h0, 3);
        check("hit_req_count", req_rises - r0, 0);
        check("hit_rdata", obs_rdata, 4'h5);

        // Write hit, read back.
        r0 = req_rises;
        txn(0, 16'h0024, 4'h3, 2);
        check("whit_req_count", req_rises - r0, 1);
        check("whit_addr", obs_addr, 15'h0012);
        check("whit_wdata", obs_wdata, 8'hA3);
        r0 = req_rises;
        txn(1, 16'h0024, 4'h0, 2);
        check("whit_readback_req", req_rises - r0, 0);
        check("whit_readback", obs_rdata, 4'h3);

        // Write miss: fetch then write.
        r0 = req_rises;
        txn(0, 16'h1001, 4'hF, 1);
        check("wmiss_req_count", req_rises - r0, 2);
        check("wmiss_addr", obs_addr, 15'h0800);
        check("wmiss_wdata", obs_wdata, 8'hF0);

        // inv coincident with the fill ack.
        force_inv = 1'b1;
        txn(1, 16'h0025, 4'h0, 2);
        force_inv = 1'b0;
        check("inv_ack_rdata", obs_rdata, 4'hA);
        r0 = req_rises;
        txn(1, 16'h0024, 4'h0, 1);
        check("inv_reread_miss", req_rises - r0, 1);
        check("inv_reread_rdata", obs_rdata, 4'h3);

        // Byte 0x7FFF and 0x0000 are unrelated tags.
        txn(1, 16'hFFFF, 4'h0, 0);
        r0 = req_rises;
        txn(1, 16'h0001, 4'h0, 0);
        check("nowrap_miss", req_rises - r0, 1);

        // Asynchronous reset during an outstanding fill.
        core_addr = 16'h0100; core_rw = 1'b1;
        set_exp(0, 0, exp_rdata, 0, 0, 0, exp_addr, exp_wdata);
        step();
        set_exp(1, 0, exp_rdata, 0, 1, 0, 15'h0080, exp_wdata);
        #6;
        chk_en = 1'b0;
        c0 = rd_cnt;
        check("pre_rst_req", ext_req, 1);
        rst = 1'b1;
        #1;
        check("async_rst_req", ext_req, 0);
        check("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        check("rst_no_rd_en", rd_cnt - c0, 0);
        chk_en = 1'b1;
        r0 = req_rises;
        txn(1, 16'h0100, 4'h0, 1);
        check("post_rst_miss", req_rises - r0, 1);

        // Randomised traffic with random inv and stray acks.
        inv_rate = 8;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 4))
                0: a = {15'h7FFF, 1'($urandom)};
                1: a = {15'h0000, 1'($urandom)};
                2: a = {15'h0012, 1'($urandom)};
                3: a = {15'h0013, 1'($urandom)};
                default: a = 16'($urandom);
            endcase
            txn(1'($urandom), a, 4'($urandom), $urandom_range(0, 4));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/misao_mem_bridge.md
MISAO_MEM_BRIDGE -- requirements
Module: misao_mem_bridge

Interface
REQ-001 SHALL have parameter BUF_EN, default 1, meaning: 1 enables the one-byte read buffer, 0 forces every access to miss.
REQ-002 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have core_addr  input  16  nibble address from core; bit 0 selects the nibble (0 = [3:0], 1 = [7:4]), bits [15:1] give the byte address.
REQ-005 SHALL have core_rw  input  1  core direction, 1 = read request, 0 = write request.
REQ-006 SHALL have core_wdata  input  4  write nibble, valid while core_wr_en is high.
REQ-007 SHALL have core_rdata  output  4  read nibble, valid while core_rd_en is high.
REQ-008 SHALL have core_rd_en  output  1  one-cycle strobe: read data valid, core advances.
REQ-009 SHALL have core_wr_en  output  1  one-cycle strobe: bridge samples core_wdata this cycle.
REQ-010 SHALL have inv  input  1  invalidate the read buffer.
REQ-011 SHALL have busy  output  1  high in every state except IDLE.
REQ-012 SHALL have ext_req, ext_we  output  1 each  external request and write-enable.
REQ-013 SHALL have ext_addr  output  15 and ext_wdata  output  8  external byte address and write byte.
REQ-014 SHALL have ext_ack  input  1 and ext_rdata  input  8  external completion and read byte, valid with ext_ack.

Function
REQ-015 SHALL have states IDLE, FILL, RESP, WCAP, WFILL, WRITE; all outputs registered.
REQ-016 SHALL in IDLE latch core_addr and core_rw every cycle a request is accepted; a request is accepted in every IDLE cycle.
REQ-017 SHALL treat a request as hit when BUF_EN=1, buffer valid and latched byte address equals buffer tag.
REQ-018 SHALL on read hit go IDLE->RESP (response one cycle after acceptance); on read miss go IDLE->FILL.
REQ-019 SHALL in FILL hold ext_req=1, ext_we=0, ext_addr stable until ext_ack sampled high, then load buffer data/tag, set valid, go RESP.
REQ-020 SHALL in RESP drive core_rd_en=1 for exactly one cycle with the selected nibble, then return to IDLE.
REQ-021 SHALL on write go IDLE->WCAP, assert core_wr_en for exactly one cycle and capture core_wdata at the end of that cycle.
REQ-022 SHALL from WCAP go WRITE on hit, else WFILL; WFILL performs an external read as in FILL, then goes WRITE.
REQ-023 SHALL in WRITE drive ext_we=1, ext_wdata = fetched/buffered byte with the selected nibble replaced, hold until ext_ack, then update buffer with the merged byte, set valid, return to IDLE.
REQ-024 SHALL deassert ext_req in the cycle after ext_ack is sampled; ext_ack outside FILL/WFILL/WRITE is ignored.
REQ-025 SHALL ignore core_addr, core_rw and core_wdata changes while busy=1.
REQ-026 SHALL clear buffer valid on inv=1; inv coincident with a fill/write ack still completes the current access with the acked data but leaves valid=0.
REQ-027 SHALL treat byte address 0x7FFF and 0x0000 as unrelated tags (no wrap merging).

Reset
REQ-028 SHALL on rst force IDLE, buffer valid=0, tag=0, data=0, and core_rd_en, core_wr_en, ext_req, ext_we, busy=0, core_rdata=0, ext_addr=0, ext_wdata=0, immediately and independent of clk.
REQ-029 SHALL abandon any outstanding external request on rst without completing it; first post-reset access is a miss.

Verification
REQ-030 Read miss: ext memory byte 0x12=0xA5, core reads 0x0025 -> ext_req with ext_addr=0x0012, ext_we=0; ack after 3 cycles -> core_rd_en one cycle with core_rdata=0xA.
REQ-031 Read hit: next read 0x0024 -> no ext_req, core_rd_en one cycle after acceptance, core_rdata=0x5.
REQ-032 Write hit: buffer holds 0xA5 at byte 0x12, core writes 0x3 to 0x0024 -> one core_wr_en, then ext_we=1, ext_addr=0x0012, ext_wdata=0xA3; subsequent read 0x0024 hits with 0x3.
REQ-033 Write miss: core writes 0xF to 0x1001, ext byte 0x0800=0x00 -> WFILL read of 0x0800, then write ext_wdata=0xF0.
REQ-034 inv during FILL ack: read 0x0025 completes with 0xA, immediate re-read of 0x0024 -> miss (new ext_req).
REQ-035 rst asserted while ext_req=1 in FILL -> ext_req, busy drop without clk edge; no core_rd_en; next read misses.
